timer_avalon_master: RTL and testbench

- Avalon-MM initiator that drives the interval-timer slave (16-bit data, 3-bit word address, 1-cycle registered read latency, no waitrequest).
- Turns simple user commands into timer register sequences: START with period, STOP, and SNAPSHOT read-back.
- Services the timer IRQ automatically by clearing status, then emits a tick pulse and counts timeouts.
- Sits between a control FSM or soft-core glue and the timer instance, on the same clock.

---
 rtl/timer_avalon_master.sv | 151 +++++++++++++++
 tb/tb_timer_avalon_master.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_avalon_master.sv
// Avalon-MM initiator for the interval-timer slave: sequences START/STOP/SNAP
// commands into register accesses and services the timeout IRQ with a tick counter.
module timer_avalon_master #(
  parameter int unsigned TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_period,
  input  logic              cmd_cont,
  input  logic              cmd_ie,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              busy,
  output logic [2:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [15:0]       m_writedata,
  input  logic [15:0]       m_readdata,
  input  logic              m_irq
);

  typedef enum logic [1:0] {OP_START, OP_STOP, OP_SNAP, OP_RSVD} op_t;

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, WR_STOP, SNAP_WR, RD_L, RD_H, RD_CAP, ACK
  } state_t;

  state_t      state, state_nx;
  logic [31:0] period_q;
  logic        cont_q, ie_q;
  logic        accept;

  always_comb begin
    cmd_ready = (state == IDLE) && !m_irq;
    accept    = cmd_valid && cmd_ready;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      period_q   <= '0;
      cont_q     <= 1'b0;
      ie_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      state     <= state_nx;
      rsp_valid <= (state == RD_CAP);
      tick      <= (state == ACK);
      if (state == ACK)
        tick_count <= tick_count + TICK_W'(1);
      // Registered read latency: the word addressed in RD_L arrives in RD_H,
      // the word addressed in RD_H arrives in RD_CAP.
      if (state == RD_H)
        rsp_data[15:0] <= m_readdata;
      if (state == RD_CAP)
        rsp_data[31:16] <= m_readdata;
      if (accept) begin
        period_q <= cmd_period;
        if (op_t'(cmd_op) == OP_START) begin
          cont_q <= cmd_cont;
          ie_q   <= cmd_ie;
        end
      end
    end
  end

  always_comb begin
    state_nx     = state;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = '0;
    m_writedata  = '0;
    case (state)
      IDLE: begin
        // IRQ service outranks any waiting command.
        if (m_irq)
          state_nx = ACK;
        else if (cmd_valid) begin
          case (op_t'(cmd_op))
            OP_START: state_nx = WR_PL;
            OP_STOP:  state_nx = WR_STOP;
            OP_SNAP:  state_nx = SNAP_WR;
            default:  state_nx = IDLE;
          endcase
        end
      end
      WR_PL: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd2;
        m_writedata  = period_q[15:0];
        state_nx     = WR_PH;
      end
      WR_PH: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd3;
        m_writedata  = period_q[31:16];
        state_nx     = WR_CTL;
      end
      WR_CTL: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd1;
        m_writedata  = {12'd0, 1'b0, 1'b1, cont_q, ie_q};
        state_nx     = IDLE;
      end
      WR_STOP: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd1;
        m_writedata  = {12'd0, 1'b1, 1'b0, cont_q, ie_q};
        state_nx     = IDLE;
      end
      SNAP_WR: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd4;
        state_nx     = RD_L;
      end
      RD_L: begin
        m_chipselect = 1'b1;
        m_address    = 3'd4;
        state_nx     = RD_H;
      end
      RD_H: begin
        m_chipselect = 1'b1;
        m_address    = 3'd5;
        state_nx     = RD_CAP;
      end
      RD_CAP: state_nx = IDLE;
      ACK: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd0;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_timer_avalon_master.sv
// Scoreboard bench for timer_avalon_master against a behavioural interval-timer
// slave; expected bus writes and snapshot responses are queued as commands issue.
module tb_timer_avalon_master;

  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [31:0]   cmd_period = '0;
  logic          cmd_cont = 1'b0;
  logic          cmd_ie = 1'b0;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          tick;
  logic [TW-1:0] tick_count;
  logic          busy;
  logic [2:0]    m_address;
  logic          m_chipselect;
  logic          m_write_n;
  logic [15:0]   m_writedata;
  logic [15:0]   m_readdata;
  logic          m_irq;

  always #5 clk = ~clk;

  timer_avalon_master #(.TICK_W(TW)) dut (
    .clk(clk), .reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_cont(cmd_cont), .cmd_ie(cmd_ie),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tick(tick), .tick_count(tick_count), .busy(busy),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_irq(m_irq)
  );

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural interval timer: down-counter, period writes reload and stop,
  // control start beats stop, status write clears the timeout flag.
  logic [15:0] t_pl, t_ph, t_rd;
  logic [31:0] t_cnt, t_snap;
  logic        t_to, t_run, t_ito, t_cont;
  int          t_timeouts;

  assign m_irq = t_to && t_ito;
  assign m_readdata = t_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t_pl <= '0; t_ph <= '0; t_rd <= '0; t_cnt <= '0; t_snap <= '0;
      t_to <= 1'b0; t_run <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0;
      t_timeouts <= 0;
    end else begin
      if (t_run) begin
        if (t_cnt == 0) begin
          t_to <= 1'b1;
          t_cnt <= {t_ph, t_pl};
          t_timeouts <= t_timeouts + 1;
          if (!t_cont) t_run <= 1'b0;
        end else begin
          t_cnt <= t_cnt - 1;
        end
      end
      if (m_chipselect && !m_write_n) begin
        case (m_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito <= m_writedata[0];
            t_cont <= m_writedata[1];
            if (m_writedata[2]) t_run <= 1'b1;
            else if (m_writedata[3]) t_run <= 1'b0;
          end
          3'd2: begin t_pl <= m_writedata; t_cnt <= {t_ph, m_writedata}; t_run <= 1'b0; end
          3'd3: begin t_ph <= m_writedata; t_cnt <= {m_writedata, t_pl}; t_run <= 1'b0; end
          3'd4, 3'd5: t_snap <= t_cnt;
          default: ;
        endcase
      end
      if (m_chipselect && m_write_n) begin
        case (m_address)
          3'd0: t_rd <= {14'd0, t_run, t_to};
          3'd1: t_rd <= {12'd0, 2'b00, t_cont, t_ito};
          3'd2: t_rd <= t_pl;
          3'd3: t_rd <= t_ph;
          3'd4: t_rd <= t_snap[15:0];
          3'd5: t_rd <= t_snap[31:16];
          default: t_rd <= '0;
        endcase
      end
    end
  end

  logic [18:0]   wq[$];
  int            rq[$];
  logic [31:0]   rsp_log[$];
  logic [18:0]   we;
  int            ec;
  int            tick_seen = 0;
  logic [TW-1:0] exp_tc = '0;
  logic          prev_ack = 1'b0;
  logic          cont_s = 1'b0, ie_s = 1'b0;

  always @(negedge clk) begin
    if (m_chipselect && !m_write_n) begin
      if (wq.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL bus_write: unexpected write addr %0d data 0x%0h, expected none", m_address, m_writedata);
      end else begin
        we = wq.pop_front();
        check("bus_write", {m_address, m_writedata}, we);
      end
    end else if (!m_chipselect) begin
      check("bus_idle", {m_address, m_write_n, m_writedata}, {3'd0, 1'b1, 16'd0});
    end
    if (rsp_valid) begin
      if (rq.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL rsp_valid: unexpected pulse at cycle %0d, expected none", cyc);
      end else begin
        ec = rq.pop_front();
        check("rsp_cycle", cyc, ec);
        check("rsp_data", rsp_data, t_snap);
        rsp_log.push_back(rsp_data);
      end
    end
    if (rst) begin
      exp_tc = '0;
      tick_seen = 0;
      prev_ack = 1'b0;
    end else begin
      if (tick) begin
        exp_tc = exp_tc + 1'b1;
        tick_seen++;
        check("tick_after_ack", prev_ack, 1'b1);
        check("tick_count", tick_count, exp_tc);
      end
      prev_ack = m_chipselect && !m_write_n && (m_address == 3'd0);
    end
  end

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    check("reset_ctl", {cmd_ready, busy, rsp_valid, tick, m_chipselect, m_write_n}, 6'b100001);
    check("reset_data", {rsp_data, m_address, m_writedata}, '0);
    check("reset_tick_count", tick_count, '0);
    check("wq_empty", wq.size(), 0);
    check("rq_empty", rq.size(), 0);
    wq.delete();
    rq.delete();
    rsp_log.delete();
    cont_s = 1'b0;
    ie_s = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply_reset();
  endtask

  // Called at a negedge; pushes expectations, waits for acceptance, then
  // optionally checks cmd_ready stays low for busy_n cycles and returns high.
  task automatic issue(input logic [1:0] op, input logic [31:0] per, input logic cont,
                       input logic ie, input int busy_n, input bit chk, output int acc);
    int budget;
    cmd_valid = 1'b1; cmd_op = op; cmd_period = per; cmd_cont = cont; cmd_ie = ie;
    budget = 0;
    while (!cmd_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      n_vec++; n_miss++;
      $display("FAIL cmd_accept: cmd_ready still 0 after %0d cycles, expected 1", budget);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    case (op)
      2'd0: begin
        wq.push_back({3'd2, per[15:0]});
        wq.push_back({3'd3, per[31:16]});
        wq.push_back({3'd1, 12'd0, 1'b0, 1'b1, cont, ie});
        cont_s = cont;
        ie_s = ie;
      end
      2'd1: wq.push_back({3'd1, 12'd0, 1'b1, 1'b0, cont_s, ie_s});
      2'd2: begin
        wq.push_back({3'd4, 16'd0});
        rq.push_back(acc + 4);
      end
      default: ;
    endcase
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_op = 2'd1; cmd_period = 32'hDEAD_BEEF;
    if (chk) begin
      for (int i = 0; i < busy_n; i++) begin
        @(negedge clk);
        check("cmd_ready_busy", cmd_ready, 1'b0);
      end
      @(negedge clk);
      check("cmd_ready_back", cmd_ready, 1'b1);
    end
  endtask

  task automatic wait_ticks(input int target, input int budget);
    int n;
    n = 0;
    while (tick_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("tick_wait", tick_seen, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, acc1, acc2, irq_cyc, n;
    logic [31:0] r0, r1;

    do_reset();

    // START 0x186A0 cont/ie, STOP, then two frozen snapshots 50 cycles apart.
    issue(2'd0, 32'h0001_86A0, 1'b1, 1'b1, 3, 1'b1, acc);
    issue(2'd1, 32'h0, 1'b0, 1'b0, 1, 1'b1, acc);
    issue(2'd2, 32'h0, 1'b0, 1'b0, 4, 1'b1, acc1);
    while (cyc < acc1 + 49) @(negedge clk);
    issue(2'd2, 32'h0, 1'b0, 1'b0, 4, 1'b1, acc2);
    check("snap_spacing_stop", acc2 - acc1, 50);
    @(negedge clk);
    check("rsp_count_stop", rsp_log.size(), 2);
    if (rsp_log.size() == 2) begin
      r0 = rsp_log[0];
      r1 = rsp_log[1];
      check("snap_frozen", r1, r0);
      check("snap_high_half", r0[31:16], 16'h0001);
    end

    // Running timer: snapshots 20 cycles apart differ by 20.
    do_reset();
    issue(2'd0, 32'd1000, 1'b1, 1'b0, 3, 1'b1, acc);
    issue(2'd2, 32'h0, 1'b0, 1'b0, 4, 1'b1, acc1);
    while (cyc < acc1 + 19) @(negedge clk);
    issue(2'd2, 32'h0, 1'b0, 1'b0, 4, 1'b1, acc2);
    check("snap_spacing_run", acc2 - acc1, 20);
    @(negedge clk);
    check("rsp_count_run", rsp_log.size(), 2);
    if (rsp_log.size() == 2) begin
      r0 = rsp_log[0];
      r1 = rsp_log[1];
      check("snap0_lt_period", r0 < 32'd1000, 1'b1);
      check("snap1_lt_period", r1 < 32'd1000, 1'b1);
      check("snap_delta", r0 - r1, 32'd20);
    end

    // IRQ pending in IDLE with SNAP waiting: ACK first, SNAP 3 cycles later.
    do_reset();
    issue(2'd0, 32'd30, 1'b0, 1'b1, 3, 1'b1, acc);
    n = 0;
    while (!m_irq && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("irq_seen", m_irq, 1'b1);
    irq_cyc = cyc;
    check("ready_low_on_irq", cmd_ready, 1'b0);
    wq.push_back({3'd0, 16'd0});
    issue(2'd2, 32'h0, 1'b0, 1'b0, 4, 1'b1, acc);
    check("snap_after_ack", acc, irq_cyc + 3);
    @(negedge clk);
    check("rsp_count_irq", rsp_log.size(), 1);
    if (rsp_log.size() == 1) begin
      r0 = rsp_log[0];
      check("snap_oneshot_reload", r0, 32'd30);
    end
    check("tick_count_irq", tick_count, 1);

    // Continuous timeouts: 3 serviced, then on to the counter wrap at 16.
    do_reset();
    issue(2'd0, 32'd9, 1'b1, 1'b1, 3, 1'b1, acc);
    for (int i = 0; i < 16; i++) wq.push_back({3'd0, 16'd0});
    wait_ticks(3, 100);
    check("tick_count_3", tick_count, 3);
    check("timeouts_3", t_timeouts, 3);
    wait_ticks(16, 400);
    check("tick_count_wrap", tick_count, 0);
    check("timeouts_16", t_timeouts, 16);

    // Reset in WR_PH abandons the sequence; a fresh START then completes.
    do_reset();
    issue(2'd0, 32'hCAFE_0042, 1'b1, 1'b1, 0, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    check("in_wr_ph", {busy, m_address, m_writedata}, {1'b1, 3'd3, 16'hCAFE});
    void'(wq.pop_back());
    apply_reset();
    issue(2'd0, 32'h1234_5678, 1'b0, 1'b0, 3, 1'b1, acc);
    issue(2'd3, 32'h0, 1'b0, 1'b0, 0, 1'b1, acc);

    repeat (5) @(negedge clk);
    check("final_wq_empty", wq.size(), 0);
    check("final_rq_empty", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
